// File: rtl/dot_product_sequencer_pkg.sv
// rtl/dot_product_sequencer_pkg.sv - shared widths and state encoding for the dot product sequencer
package dot_product_sequencer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/multiply_and_add.sv
// rtl/multiply_and_add.sv - unsigned multiply-accumulate, result truncated to 2*DATA_WIDTH
module multiply_and_add #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   a_value,
    input  logic [DATA_WIDTH-1:0]   b_value,
    input  logic [2*DATA_WIDTH-1:0] add_value,
    output logic [2*DATA_WIDTH-1:0] sum
);

    localparam int ACC_WIDTH = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] product;

    assign product = ACC_WIDTH'(a_value) * ACC_WIDTH'(b_value);
    assign sum     = add_value + product;

endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - sequences VECTOR_LENGTH input/weight beats into one biased dot product
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int VECTOR_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] bias_value,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   input_value,
    input  logic [DATA_WIDTH-1:0]   weight_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    busy
);

    localparam int ACC_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(VECTOR_LENGTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(VECTOR_LENGTH - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] accumulator;
    logic [ACC_WIDTH-1:0] mac_sum;
    logic [CNT_WIDTH-1:0] beat_count;
    logic                 beat_accept;

    assign beat_accept = in_valid && in_ready;

    multiply_and_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .a_value   (input_value),
        .b_value   (weight_value),
        .add_value (accumulator),
        .sum       (mac_sum)
    );

    // in_ready/out_valid/busy/result are registered alongside the state so they change exactly with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            accumulator <= '0;
            beat_count  <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        accumulator <= bias_value;
                        beat_count  <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_accept) begin
                        accumulator <= mac_sum;
                        beat_count  <= beat_count + 1'b1;
                        if (beat_count == LAST_BEAT) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            result    <= mac_sum;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - scoreboard bench for dot_product_sequencer
module tb_dot_product_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bias_value;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  input_value;
    logic [7:0]  weight_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int total;
    int bad;
    logic [15:0] sb[$];
    logic [15:0] model_acc;

    dot_product_sequencer #(
        .DATA_WIDTH    (8),
        .VECTOR_LENGTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bias_value   (bias_value),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_value  (input_value),
        .weight_value (weight_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic begin_run(input logic [15:0] bias);
        start      = 1'b1;
        bias_value = bias;
        model_acc  = bias;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_accept: busy=%0b in_ready=%0b expected 1/1", busy, in_ready);
        end
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input int gap, input logic last);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            input_value  = 8'hA5;
            weight_value = 8'h5A;
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
            end
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: in_ready=%0b expected 1", in_ready);
        end
        input_value  = a;
        weight_value = b;
        in_valid     = 1'b1;
        model_acc    = model_acc + 16'(a) * 16'(b);
        if (last) sb.push_back(model_acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        int waited = 0;
        logic [15:0] exp_val;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: out_valid=%0b expected 1 within 20 cycles", name, out_valid);
            return;
        end
        exp_val = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        total++;
        if (result !== exp_val) begin
            bad++;
            $display("FAIL %s_result: got %0d expected %0d", name, result, exp_val);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_ready: in_ready=%0b expected 0", name, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: out_valid=%0b busy=%0b expected 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b result=%0d expected all 0",
                     in_ready, out_valid, busy, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        begin_run(16'd10);
        send_beat(8'd1, 8'd2, 0, 1'b0);
        send_beat(8'd3, 8'd4, 0, 1'b0);
        send_beat(8'd5, 8'd6, 0, 1'b0);
        send_beat(8'd7, 8'd8, 0, 1'b1);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_latency: out_valid=%0b expected 1 one cycle after last beat", out_valid);
        end
        collect("b2b");
    endtask

    task automatic test_wrap();
        begin_run(16'd0);
        for (int i = 0; i < 4; i++) send_beat(8'd255, 8'd255, 0, i == 3);
        collect("wrap");
    endtask

    task automatic test_gaps();
        begin_run(16'd10);
        send_beat(8'd1, 8'd2, 3, 1'b0);
        send_beat(8'd3, 8'd4, 3, 1'b0);
        send_beat(8'd5, 8'd6, 3, 1'b0);
        send_beat(8'd7, 8'd8, 3, 1'b1);
        collect("gaps");
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        begin_run(16'd7);
        for (int i = 0; i < 4; i++) send_beat(8'(i + 2), 8'd9, 0, i == 3);
        held = result;
        for (int c = 0; c < 5; c++) begin
            start      = c[0];
            bias_value = 16'hBEEF;
            in_valid   = 1'b1;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stable: out_valid=%0b result=%0d in_ready=%0b expected 1/%0d/0",
                         out_valid, result, in_ready, held);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        collect("bp");
        begin_run(16'd3);
        for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, 0, i == 3);
        collect("bp_next");
    endtask

    task automatic test_reset_abort();
        begin_run(16'd5);
        send_beat(8'd9, 8'd9, 0, 1'b0);
        send_beat(8'd9, 8'd9, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0) begin
            bad++;
            $display("FAIL abort_async: in_ready=%0b out_valid=%0b busy=%0b result=%0d expected all 0",
                     in_ready, out_valid, busy, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin_run(16'd1);
        for (int i = 0; i < 4; i++) send_beat(8'd2, 8'd3, 0, i == 3);
        collect("abort_rerun");
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        bias_value   = '0;
        in_valid     = 1'b0;
        input_value  = '0;
        weight_value = '0;
        out_ready    = 1'b0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_gaps();
        test_backpressure();
        test_reset_abort();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
